// File: rtl/result_frame_collector.sv
// result_frame_collector: collects clamped filter results into a raster frame buffer, then streams the frame out.
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start           arms collection of a new frame (honoured only when idle)
//   in_valid/in_ready/in_pixel     signed IN_W-bit filter results, accepted only while filling
//   frame_done      one-cycle pulse after the final input pixel is written
//   out_valid/out_ready/out_pixel  stored 8-bit pixels, raster order
//   out_last        marks the final pixel of the frame
//   busy            high whenever a frame is being collected or drained
// Build option: define RESULT_CLAMP_EN to saturate results to 0..255 (needs IN_W >= 10);
// otherwise results are truncated to their low 8 bits.
module result_frame_collector #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int IN_W  = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_pixel,
    output logic            in_ready,
    output logic            frame_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_pixel,
    output logic            out_last,
    output logic            busy
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, PRIME, DRAIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] wr_addr, rd_addr, rd_next;
    logic [7:0]    mem [N];
    logic [7:0]    wr_data;
    logic          wr_en, hs, rd_en;

`ifdef RESULT_CLAMP_EN
    assign wr_data = in_pixel[IN_W-1] ? 8'h00 : (|in_pixel[IN_W-2:8]) ? 8'hFF : in_pixel[7:0];
`else
    logic unused_hi;
    assign unused_hi = ^in_pixel[IN_W-1:8];
    assign wr_data   = in_pixel[7:0];
`endif

    // Row-major address: with IMG_W a power of two, row*IMG_W+col is a plain linear count.
    assign wr_en   = state == FILL && in_valid;
    assign hs      = state == DRAIN && out_ready;
    // Single read port: address 0 when priming, otherwise the next pixel after a handshake.
    assign rd_en   = state == PRIME || (hs && rd_addr != LAST);
    assign rd_next = state == PRIME ? '0 : rd_addr + 1'b1;

    always_comb begin
        state_nx   = state;
        in_ready   = state == FILL;
        frame_done = state == PRIME;
        out_valid  = state == DRAIN;
        out_last   = state == DRAIN && rd_addr == LAST;
        busy       = state != IDLE;
        case (state)
            IDLE:    if (start) state_nx = FILL;
            FILL:    if (wr_en && wr_addr == LAST) state_nx = PRIME;
            PRIME:   state_nx = DRAIN;
            DRAIN:   if (hs && rd_addr == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            out_pixel <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == IDLE && start)
                wr_addr <= '0;
            else if (wr_en)
                wr_addr <= wr_addr + 1'b1;
            if (rd_en) begin
                rd_addr   <= rd_next;
                out_pixel <= mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_result_frame_collector.sv
// tb_result_frame_collector: self-checking bench for result_frame_collector (64x64, IN_W=12).
module tb_result_frame_collector;
    localparam int W = 64;
    localparam int H = 64;
    localparam int N = W * H;

    typedef struct {
        int         din;
        logic [7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_pixel = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, frame_done, out_valid, out_last, busy;
    logic [7:0]  out_pixel;

    int          n_chk = 0;
    int          n_fail = 0;
    int          fd_bad = 0;
    int          din [N];
    logic [7:0]  got [N];
    logic [7:0]  ref0 [N];
    vec_t        tbl [5];

    always #5 clk = ~clk;

    result_frame_collector #(.IMG_W(W), .IMG_H(H), .IN_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready), .frame_done(frame_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last), .busy(busy)
    );

    // Reference: the stored byte is the input value saturated to 0..255 (clamp build)
    // or the input value reduced modulo 256 (truncating build).
    function automatic logic [7:0] model(int v);
`ifdef RESULT_CLAMP_EN
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return 8'(v);
`else
        return 8'(((v % 256) + 256) % 256);
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
    endtask

    task automatic feed(bit gaps, bit inject_start);
        int i = 0;
        int cyc = 0;
        bit acc;
        bit injected = 0;
        while (i < N && cyc < 20 * N) begin
            in_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
            in_pixel = 12'(din[i]);
            if (inject_start && !injected && i == 100) begin
                start = 1'b1;
                injected = 1;
            end
            @(negedge clk);
            if (frame_done) fd_bad++;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < N) begin
            check("feed_timeout", i, N);
            return;
        end
        check("frame_done_prime", {frame_done, out_valid, busy}, 3'b101);
        @(posedge clk); #1;
        check("first_out_valid", {out_valid, frame_done}, 2'b10);
        check("first_out_pixel", out_pixel, model(din[0]));
    endtask

    task automatic drain(int pct, int stop);
        int k = 0;
        int cyc = 0;
        bit held = 0;
        logic [7:0] hp = '0;
        logic hl = 1'b0;
        while (k < stop && cyc < 40 * N) begin
            out_ready = $urandom_range(99) < pct;
            @(negedge clk);
            if (frame_done) fd_bad++;
            if (held) check("hold_stable", {out_valid, out_last, out_pixel}, {1'b1, hl, hp});
            if (out_valid && out_ready) begin
                check("pixel", out_pixel, model(din[k]));
                check("last", out_last, k == N - 1);
                got[k] = out_pixel;
                k++;
            end
            held = out_valid && !out_ready;
            hp = out_pixel;
            hl = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (k < stop) begin
            check("drain_timeout", k, stop);
            return;
        end
        if (stop == N) begin
            check("after_last", {out_valid, out_last, busy}, 3'b000);
            check("frame_done_extra", fd_bad, 0);
        end
        fd_bad = 0;
    endtask

    initial begin
        int mism;
`ifdef RESULT_CLAMP_EN
        tbl[0] = '{-5, 8'h00};
        tbl[1] = '{0, 8'h00};
        tbl[2] = '{255, 8'hFF};
        tbl[3] = '{256, 8'hFF};
        tbl[4] = '{2047, 8'hFF};
`else
        tbl[0] = '{-5, 8'hFB};
        tbl[1] = '{0, 8'h00};
        tbl[2] = '{255, 8'hFF};
        tbl[3] = '{256, 8'h00};
        tbl[4] = '{2047, 8'hFF};
`endif
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_outputs", {in_ready, out_valid, busy, frame_done, out_last}, 5'b0);
        check("reset_out_pixel", out_pixel, 8'h00);
        @(posedge clk); #1;
        check("idle_ignores_in_valid", {in_ready, busy}, 2'b00);
        in_valid = 1'b0;

        for (int i = 0; i < N; i++) din[i] = i % 256;
        do_start();
        feed(0, 0);
        drain(100, N);
        for (int i = 0; i < N; i++) ref0[i] = got[i];

        do_start();
        feed(1, 0);
        drain(30, N);
        mism = 0;
        for (int i = 0; i < N; i++) if (got[i] !== ref0[i]) mism++;
        check("backpressure_vs_gapfree", mism, 0);

        for (int j = 0; j < 5; j++) din[j] = tbl[j].din;
        do_start();
        feed(0, 1);
        drain(100, 10);
        for (int j = 0; j < 5; j++) check("clamp_table", got[j], tbl[j].exp);
        check("mid_drain", {busy, out_valid}, 2'b11);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_reset", {out_valid, out_last, busy, in_ready, frame_done}, 5'b0);
        rst_n = 1'b1;
        check("fd_during_abort", fd_bad, 0);
        fd_bad = 0;

        for (int i = 0; i < N; i++) din[i] = int'($urandom_range(4095)) - 2048;
        do_start();
        feed(0, 0);
        drain(100, N);

        for (int i = 0; i < N; i++) din[i] = 255 - (i % 256);
        do_start();
        feed(0, 0);
        drain(100, N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
